multdiv_ctrl: RTL and testbench

- Execute-stage sequencer for HI/LO-class instructions: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MUL, MTHI, MTLO.
- Owns the architectural HI/LO registers and schedules the shared multiplier and the iterative divider.
- Raises busy to stall the pipeline while an operation is in flight.
- Accepts one request at a time from the execute stage; commits results unless flushed by the exception/branch logic.

---
 rtl/common_pkg.sv | 8 +
 rtl/decode_pkg.sv | 25 ++
 rtl/multdiv_pkg.sv | 43 ++++
 rtl/multdiv_ctrl_div_iter.sv | 84 ++++++++
 rtl/multdiv_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/common_pkg.sv
// Shared scalar types used across the execute-stage blocks.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package common_pkg;

  typedef logic [31:0] word_t;

endpackage : common_pkg

// File: rtl/decode_pkg.sv
// Decoded operation codes produced by the decode stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package decode_pkg;

  typedef enum logic [6:0] {
    OP_NOP   = 7'h00,
    OP_ADD   = 7'h01,
    OP_SUB   = 7'h02,
    OP_MFHI  = 7'h10,
    OP_MFLO  = 7'h11,
    OP_MTHI  = 7'h12,
    OP_MTLO  = 7'h13,
    OP_MULT  = 7'h20,
    OP_MULTU = 7'h21,
    OP_MADD  = 7'h22,
    OP_MADDU = 7'h23,
    OP_MSUB  = 7'h24,
    OP_MSUBU = 7'h25,
    OP_MUL   = 7'h26,
    OP_DIV   = 7'h30,
    OP_DIVU  = 7'h31
  } decoded_op_t;

endpackage : decode_pkg

// File: rtl/multdiv_pkg.sv
// Types and op-class helpers for the HI/LO multiply/divide sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a (types and pure functions only).
package multdiv_pkg;

  import common_pkg::*;
  import decode_pkg::*;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdstate_t;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

  // Accept edge to commit edge for a full-length divide: 32 iterations + fixup + done.
  localparam int unsigned DIV_FULL_LAT = 34;

  function automatic logic is_mult_op(input decoded_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input decoded_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input decoded_op_t op);
    case (op)
      OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage : multdiv_pkg

// File: rtl/multdiv_ctrl_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: ITERS cycles after start_i; done_o is high in the cycle of the final iteration,
//          quo_o/rem_o hold the result from the following cycle until the next start.
// Backpressure: none; start_i is only legal when idle, flush_i abandons the run.
// Ports: clk, reset (sync, active-high), start_i/flush_i control, dividend_i/divisor_i
//        sampled on start_i, done_o, quo_o, rem_o.
module div_iter #(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);
  import common_pkg::*;

  logic        run_q, run_d;
  logic [5:0]  cnt_q, cnt_d;
  word_t       quo_q, quo_d;
  word_t       rem_q, rem_d;
  word_t       dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    done_o  = 1'b0;
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (flush_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (run_q) begin
      // diff[32] is the borrow: set when the trial subtraction went negative.
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(ITERS - 1)) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule : div_iter

// File: rtl/multdiv_ctrl.sv
// Execute-stage HI/LO sequencer: owns HI/LO, schedules the pipelined multiplier and iterative divider.
// Latency: MTHI/MTLO 0 (write at accept edge); mult-class MULT_LAT+1 busy cycles; divide 34 busy cycles
//          (1 with early-out on trivial divides when MULTDIV_DIV_EARLY_OUT_EN is defined).
// Backpressure: req_ready_o only in IDLE; busy_o stalls the pipeline; flush_i aborts without commit.
// Ports: clk, reset (sync, active-high); req_valid_i/req_ready_o/op_i/src_a_i/src_b_i request;
//        flush_i abort; busy_o, done_o (commit pulse), mul_res_o (MUL result during done_o), hi_o, lo_o.
module multdiv_ctrl
  import common_pkg::*;
  import decode_pkg::*;
  import multdiv_pkg::*;
#(
  parameter int unsigned MULT_LAT  = 2,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  decoded_op_t op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] mul_res_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  mdstate_t    state_q, state_d;
  decoded_op_t op_q, op_d;
  word_t       opa_q, opa_d;
  word_t       opb_q, opb_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        divz_q, divz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t       res_q, res_d;
  hilo_t       hilo_q, hilo_d;
  logic [63:0] prod_q [MULT_LAT];
  logic [63:0] prod_d [MULT_LAT];

  logic        accept;
  logic        sgn_in;
  logic        a_neg, b_neg;
  word_t       a_mag, b_mag;
  logic        mul_sgn;
  logic [63:0] ext_a, ext_b;
  logic [63:0] prod;
  logic        div_start;
  logic        div_done;
  word_t       div_quo, div_rem;
  word_t       q_fix, r_fix;

  div_iter #(.ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start_i   (div_start),
    .flush_i   (flush_i),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .done_o    (div_done),
    .quo_o     (div_quo),
    .rem_o     (div_rem)
  );

  // Request-side operand conditioning: the divider only sees magnitudes.
  always_comb begin
    sgn_in = is_signed_op(op_i);
    a_neg  = sgn_in & src_a_i[31];
    b_neg  = sgn_in & src_b_i[31];
    a_mag  = a_neg ? -src_a_i : src_a_i;
    b_mag  = b_neg ? -src_b_i : src_b_i;
    accept = req_valid_i & req_ready_o & ~flush_i;
  end

  // Multiplier: a 64x64 product of the extended operands is exact mod 2^64 for both
  // signed and unsigned ops; the result then walks down MULT_LAT register stages.
  always_comb begin
    mul_sgn   = is_signed_op(op_q);
    ext_a     = {{32{mul_sgn & opa_q[31]}}, opa_q};
    ext_b     = {{32{mul_sgn & opb_q[31]}}, opb_q};
    prod_d[0] = ext_a * ext_b;
    for (int i = 1; i < int'(MULT_LAT); i++) begin
      prod_d[i] = prod_q[i-1];
    end
    prod = prod_q[MULT_LAT-1];
  end

  always_comb begin
    q_fix = (sa_q ^ sb_q) ? -div_quo : div_quo;
    r_fix = sa_q ? -div_rem : div_rem;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    divz_d    = divz_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    hilo_d    = hilo_q;
    div_start = 1'b0;
    done_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_i == OP_MTHI) begin
            hilo_d.hi = src_a_i;
          end else if (op_i == OP_MTLO) begin
            hilo_d.lo = src_a_i;
          end else if (is_mult_op(op_i)) begin
            op_d    = op_i;
            opa_d   = src_a_i;
            opb_d   = src_b_i;
            cnt_d   = CNT_W'(MULT_LAT - 1);
            state_d = MUL;
          end else if (is_div_op(op_i)) begin
            op_d   = op_i;
            sa_d   = a_neg;
            sb_d   = b_neg;
            divz_d = (src_b_i == '0);
`ifdef MULTDIV_DIV_EARLY_OUT_EN
            // |a| < |b| means quotient 0 and remainder a itself (sign already that of a).
            if ((src_b_i == '0) || (a_mag < b_mag)) begin
              res_d.hi = src_a_i;
              res_d.lo = '0;
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = DIV;
            end
`else
            div_start = 1'b1;
            state_d   = DIV;
`endif
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV: begin
        if (div_done) state_d = FIX;
      end
      FIX: begin
        res_d.lo = q_fix;
        res_d.hi = r_fix;
        state_d  = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
        if (is_mult_op(op_q)) begin
          case (op_q)
            OP_MULT, OP_MULTU: hilo_d = hilo_t'(prod);
            OP_MADD, OP_MADDU: hilo_d = hilo_t'(hilo_q + prod);
            OP_MSUB, OP_MSUBU: hilo_d = hilo_t'(hilo_q - prod);
            default:           hilo_d = hilo_q;
          endcase
        end else if (!divz_q) begin
          hilo_d = res_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything in flight: back to IDLE with HI/LO untouched.
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      hilo_d  = hilo_q;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      opa_q   <= '0;
      opb_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      divz_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      hilo_q  <= '0;
      for (int i = 0; i < int'(MULT_LAT); i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      divz_q  <= divz_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hilo_q  <= hilo_d;
      for (int i = 0; i < int'(MULT_LAT); i++) prod_q[i] <= prod_d[i];
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign hi_o        = hilo_q.hi;
  assign lo_o        = hilo_q.lo;
  assign mul_res_o   = ((state_q == DONE) && (op_q == OP_MUL)) ? prod[31:0] : '0;

endmodule : multdiv_ctrl

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;
  import common_pkg::*;
  import decode_pkg::*;
  import multdiv_pkg::*;

  localparam int unsigned MULT_LAT = 2;
  localparam int MUL_BUSY = MULT_LAT + 1;
`ifdef MULTDIV_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  decoded_op_t op_i = OP_NOP;
  word_t       src_a_i = '0;
  word_t       src_b_i = '0;
  logic        req_ready_o, busy_o, done_o;
  word_t       mul_res_o, hi_o, lo_o;

  typedef struct {
    word_t hi;
    word_t lo;
    word_t mul;
    bit    is_mul;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  word_t m_hi = '0;
  word_t m_lo = '0;
  int    nd;

  multdiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_ITERS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mul_res_o  (mul_res_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int div_busy(input word_t a, input word_t b, input bit sgn);
    word_t ma, mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (EARLY && ((b == 0) || (ma < mb))) return 1;
    return DIV_FULL_LAT;
  endfunction

  // Architectural reference model of HI/LO.
  task automatic model(input decoded_op_t op, input word_t a, input word_t b, output exp_t e);
    logic [63:0] acc, up;
    longint      sa64, sb64, sp;
    int          sq, sr;
    acc  = {m_hi, m_lo};
    sa64 = $signed(a);
    sb64 = $signed(b);
    sp   = sa64 * sb64;
    up   = {32'd0, a} * {32'd0, b};
    e.mul = '0;
    e.is_mul = 1'b0;
    case (op)
      OP_MTHI:  m_hi = a;
      OP_MTLO:  m_lo = a;
      OP_MULT:  acc = sp;
      OP_MULTU: acc = up;
      OP_MADD:  acc = acc + sp;
      OP_MADDU: acc = acc + up;
      OP_MSUB:  acc = acc - sp;
      OP_MSUBU: acc = acc - up;
      OP_MUL: begin e.mul = sp[31:0]; e.is_mul = 1'b1; end
      OP_DIV: if (b != 0) begin
        sq  = $signed(a) / $signed(b);
        sr  = $signed(a) % $signed(b);
        acc = {sr, sq};
      end
      OP_DIVU: if (b != 0) acc = {a % b, a / b};
      default: ;
    endcase
    if (op != OP_MTHI && op != OP_MTLO) {m_hi, m_lo} = acc;
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic do_op(input string tag, input decoded_op_t op, input word_t a, input word_t b,
                       input int exp_busy);
    exp_t e, got;
    int   cyc, ndone;
    cyc = 0;
    ndone = 0;
    model(op, a, b, e);
    got = e;
    if (exp_busy > 0) sb_q.push_back(e);
    @(negedge clk);
    req_valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    @(negedge clk);
    if (exp_busy > 0) begin
      // Keep offering an MTHI while busy: it must not be taken.
      op_i = OP_MTHI; src_a_i = 32'hBAD0BAD0;
      check({tag, " ready_while_busy"}, 32'(req_ready_o), 32'd0);
    end else begin
      req_valid_i = 1'b0;
    end
    while (busy_o === 1'b1 && cyc < 200) begin
      cyc++;
      if (done_o === 1'b1) begin
        ndone++;
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          if (got.is_mul) check({tag, " mul_res"}, mul_res_o, got.mul);
        end
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    if (exp_busy > 0 && ndone == 0 && sb_q.size() > 0) void'(sb_q.pop_front());
    check({tag, " busy_cycles"}, cyc, exp_busy);
    check({tag, " done_pulses"}, ndone, (exp_busy > 0) ? 1 : 0);
    check({tag, " hi"}, hi_o, got.hi);
    check({tag, " lo"}, lo_o, got.lo);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(req_ready_o), 32'd1);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst hi", hi_o, 32'd0);
    check("rst lo", lo_o, 32'd0);
    check("rst mul_res", mul_res_o, 32'd0);
    reset = 1'b0;

    do_op("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, MUL_BUSY);
    check("mult hi const", hi_o, 32'hFFFFFFFF);
    check("mult lo const", lo_o, 32'hFFFFFFF1);

    do_op("mthi", OP_MTHI, 32'd0, 32'd0, 0);
    do_op("mtlo", OP_MTLO, 32'hFFFFFFFF, 32'd0, 0);
    do_op("maddu", OP_MADDU, 32'd1, 32'd1, MUL_BUSY);
    check("maddu hi const", hi_o, 32'h00000001);
    check("maddu lo const", lo_o, 32'h00000000);

    do_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, div_busy(32'hFFFFFFF9, 32'd2, 1'b1));
    check("div lo const", lo_o, 32'hFFFFFFFD);
    check("div hi const", hi_o, 32'hFFFFFFFF);

    // Flush a DIVU in its tenth busy cycle.
    nd = 0;
    @(negedge clk);
    req_valid_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd1000; src_b_i = 32'd7;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done_o === 1'b1) nd++;
      @(negedge clk);
    end
    check("flush busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush busy_after", 32'(busy_o), 32'd0);
    check("flush ready_after", 32'(req_ready_o), 32'd1);
    repeat (3) begin
      if (done_o === 1'b1) nd++;
      @(negedge clk);
    end
    check("flush no_done", nd, 0);
    check("flush hi", hi_o, m_hi);
    check("flush lo", lo_o, m_lo);
    do_op("multu_after_flush", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_BUSY);

    do_op("mthi2", OP_MTHI, 32'h12345678, 32'd0, 0);
    do_op("mtlo2", OP_MTLO, 32'h12345678, 32'd0, 0);
    do_op("mul", OP_MUL, 32'd7, 32'd6, MUL_BUSY);
    check("mul hi const", hi_o, 32'h12345678);
    check("mul lo const", lo_o, 32'h12345678);

    do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, div_busy(32'd5, 32'd0, 1'b0));
    do_op("msub", OP_MSUB, 32'hFFFFFFFE, 32'd9, MUL_BUSY);
    do_op("msubu", OP_MSUBU, 32'd3, 32'h80000000, MUL_BUSY);
    do_op("madd", OP_MADD, 32'h80000000, 32'h80000000, MUL_BUSY);
    do_op("div_negb", OP_DIV, 32'd100, 32'hFFFFFFF9, div_busy(32'd100, 32'hFFFFFFF9, 1'b1));
    do_op("divu_small", OP_DIVU, 32'd3, 32'd10, div_busy(32'd3, 32'd10, 1'b0));
    do_op("div_small_neg", OP_DIV, 32'hFFFFFFFD, 32'd10, div_busy(32'hFFFFFFFD, 32'd10, 1'b1));
    do_op("div_by0_signed", OP_DIV, 32'hFFFFFF00, 32'd0, div_busy(32'hFFFFFF00, 32'd0, 1'b1));
    do_op("non_hilo", OP_ADD, 32'd1, 32'd2, 0);

    // Flush in the same cycle as the request: nothing accepted.
    @(negedge clk);
    req_valid_i = 1'b1; op_i = OP_MTHI; src_a_i = 32'hFACEFACE; flush_i = 1'b1;
    @(negedge clk);
    op_i = OP_MULT; src_a_i = 32'd3; src_b_i = 32'd4;
    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("sameflush busy", 32'(busy_o), 32'd0);
    check("sameflush hi", hi_o, m_hi);
    check("sameflush lo", lo_o, m_lo);

    // Reset in the middle of a divide.
    @(negedge clk);
    req_valid_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd77; src_b_i = 32'd5;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst busy_before", 32'(busy_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst ready", 32'(req_ready_o), 32'd1);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst hi", hi_o, 32'd0);
    check("midrst lo", lo_o, 32'd0);
    do_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, div_busy(32'd100, 32'd7, 1'b0));
    check("sb empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multdiv_ctrl
